// File: rtl/button_ctrl.sv
// Front panel button controller: per-button synchroniser, debouncer and edge detector
// driving LEDs either as per-button toggles (MODE 0) or as an up/down counter (MODE 1).
module button_ctrl #(
    parameter int N_BUTTONS       = 2,
    parameter int N_LEDS          = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int MODE            = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_BUTTONS-1:0] buttons,
    output logic [N_BUTTONS-1:0] pressed,
    output logic [N_BUTTONS-1:0] press_pulse,
    output logic [N_BUTTONS-1:0] release_pulse,
    output logic [N_LEDS-1:0]    led
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int N_TOG = (N_BUTTONS < N_LEDS) ? N_BUTTONS : N_LEDS;

    logic [N_BUTTONS-1:0] sync_p0;
    logic [N_BUTTONS-1:0] sync_p1;
    logic [CNT_W-1:0]     cnt [N_BUTTONS];
    logic [N_BUTTONS:0]   pulse_ext;
    logic [N_LEDS-1:0]    led_next;
    logic                 clr;

    // Stage p0/p1: two-flop synchroniser, then debounce against the accepted level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0       <= '0;
            sync_p1       <= '0;
            pressed       <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            for (int i = 0; i < N_BUTTONS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync_p0 <= buttons;
            sync_p1 <= sync_p0;
            for (int i = 0; i < N_BUTTONS; i++) begin
                press_pulse[i]   <= 1'b0;
                release_pulse[i] <= 1'b0;
                if (sync_p1[i] == pressed[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    pressed[i]       <= sync_p1[i];
                    cnt[i]           <= '0;
                    press_pulse[i]   <= sync_p1[i];
                    release_pulse[i] <= ~sync_p1[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Padding keeps index 1 legal even for a single-button toggle build
    assign pulse_ext = {1'b0, press_pulse};

    always_comb begin
        led_next = led;
        clr      = 1'b0;
        if (MODE == 0) begin
            for (int i = 0; i < N_TOG; i++) begin
                led_next[i] = led[i] ^ press_pulse[i];
            end
        end else begin
            for (int i = 2; i < N_BUTTONS; i++) begin
                clr = clr | press_pulse[i];
            end
            if (clr) begin
                led_next = '0;
            end else if (pulse_ext[0] && !pulse_ext[1]) begin
                led_next = led + N_LEDS'(1);
            end else if (pulse_ext[1] && !pulse_ext[0]) begin
                led_next = led - N_LEDS'(1);
            end
        end
    end

    // Stage p2: LED register follows the registered press pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led <= '0;
        end else begin
            led <= led_next;
        end
    end

endmodule

// File: tb/tb_button_ctrl.sv
// Bench for button_ctrl: toggle and counter builds share one stimulus and are
// compared every cycle against a sample-window reference model.
module tb_button_ctrl;

    localparam int NB = 3;
    localparam int NL = 4;
    localparam int DB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] buttons = '0;

    logic [NB-1:0] pressed0, pp0, rp0;
    logic [NB-1:0] pressed1, pp1, rp1;
    logic [NL-1:0] led0, led1;

    button_ctrl #(.N_BUTTONS(NB), .N_LEDS(NL), .DEBOUNCE_CYCLES(DB), .MODE(0)) dut_tog (
        .clk(clk), .rst(rst), .buttons(buttons), .pressed(pressed0),
        .press_pulse(pp0), .release_pulse(rp0), .led(led0)
    );

    button_ctrl #(.N_BUTTONS(NB), .N_LEDS(NL), .DEBOUNCE_CYCLES(DB), .MODE(1)) dut_cnt (
        .clk(clk), .rst(rst), .buttons(buttons), .pressed(pressed1),
        .press_pulse(pp1), .release_pulse(rp1), .led(led1)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: raw pin samples, newest first, and the expected outputs
    logic [NB-1:0] hist [0:DB+1];
    logic [NB-1:0] m_pressed, m_pp, m_rp;
    logic [NL-1:0] m_led0, m_led1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int j = 0; j <= DB + 1; j++) hist[j] = '0;
        m_pressed = '0;
        m_pp      = '0;
        m_rp      = '0;
        m_led0    = '0;
        m_led1    = '0;
    endtask

    // A level is accepted once the DB samples seen two edges late all disagree with it
    task automatic model_step();
        logic [NB-1:0] flip;
        for (int i = 0; i < NB && i < NL; i++)
            if (m_pp[i]) m_led0[i] = ~m_led0[i];
        if (m_pp[2])                  m_led1 = '0;
        else if (m_pp[0] && !m_pp[1]) m_led1 = m_led1 + 4'd1;
        else if (m_pp[1] && !m_pp[0]) m_led1 = m_led1 - 4'd1;
        for (int j = DB + 1; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = buttons;
        flip = '1;
        for (int b = 0; b < NB; b++)
            for (int j = 2; j <= DB + 1; j++)
                if (hist[j][b] == m_pressed[b]) flip[b] = 1'b0;
        m_pp      = flip & ~m_pressed;
        m_rp      = flip & m_pressed;
        m_pressed = m_pressed ^ flip;
    endtask

    task automatic compare_all();
        chk("pressed_tog", 32'(pressed0), 32'(m_pressed));
        chk("press_pulse_tog", 32'(pp0), 32'(m_pp));
        chk("release_pulse_tog", 32'(rp0), 32'(m_rp));
        chk("led_tog", 32'(led0), 32'(m_led0));
        chk("pressed_cnt", 32'(pressed1), 32'(m_pressed));
        chk("press_pulse_cnt", 32'(pp1), 32'(m_pp));
        chk("release_pulse_cnt", 32'(rp1), 32'(m_rp));
        chk("led_cnt", 32'(led1), 32'(m_led1));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_clear();
        else     model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_clear();
        chk("rst_pressed", 32'(pressed0), 32'd0);
        chk("rst_pulses", 32'({pp0, rp0}), 32'd0);
        chk("rst_led_tog", 32'(led0), 32'd0);
        chk("rst_led_cnt", 32'(led1), 32'd0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic edges_until(input int b, input logic v, output int n);
        n = 99;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (pressed0[b] === v) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic press(input logic [NB-1:0] mask);
        buttons = buttons | mask;
        repeat (8) tick();
        buttons = buttons & ~mask;
        repeat (8) tick();
    endtask

    initial begin
        int n;
        int np;
        model_clear();
        #2;
        do_reset();

        // Reset mid-run with all buttons held
        buttons = 3'b111;
        repeat (3) tick();
        do_reset();
        edges_until(0, 1'b1, n);
        chk("rst_relatch_latency", n, 6);
        chk("rst_relatch_pressed", 32'(pressed0), 32'h7);
        chk("rst_relatch_pulse", 32'(pp0), 32'h7);
        tick();
        chk("rst_relatch_pulse_end", 32'(pp0), 32'h0);
        buttons = '0;
        repeat (10) tick();
        do_reset();

        // Clean press and release of button 0
        buttons[0] = 1'b1;
        edges_until(0, 1'b1, n);
        chk("clean_press_latency", n, 6);
        chk("clean_press_pulse", 32'(pp0), 32'h1);
        tick();
        chk("clean_press_led", 32'(led0), 32'h1);
        chk("clean_press_pulse_end", 32'(pp0), 32'h0);
        repeat (13) tick();
        buttons[0] = 1'b0;
        edges_until(0, 1'b0, n);
        chk("clean_release_latency", n, 6);
        chk("clean_release_pulse", 32'(rp0), 32'h1);
        tick();
        chk("clean_release_led", 32'(led0), 32'h1);

        // Bounce on button 1, then a settle high
        np = 0;
        for (int k = 0; k < 28; k++) begin
            if (k % 2 == 0) buttons[1] = ~buttons[1];
            tick();
            np += int'(pp0[1]);
        end
        chk("bounce_no_pulse", np, 0);
        buttons[1] = 1'b1;
        edges_until(1, 1'b1, n);
        chk("bounce_settle_latency", n, 6);
        chk("bounce_settle_pulse", 32'(pp0[1]), 32'h1);
        tick();
        chk("bounce_settle_pulse_end", 32'(pp0[1]), 32'h0);
        buttons[1] = 1'b0;
        repeat (10) tick();
        np = 0;
        buttons[1] = 1'b1;
        repeat (3) begin tick(); np += int'(pp0[1]); end
        buttons[1] = 1'b0;
        repeat (10) begin tick(); np += int'(pp0[1]); end
        chk("glitch_no_pulse", np, 0);

        // Counter wrap in both directions
        press(3'b100);
        chk("cnt_clear", 32'(led1), 32'h0);
        repeat (15) press(3'b001);
        chk("cnt_up_15", 32'(led1), 32'hF);
        press(3'b001);
        chk("cnt_wrap_up", 32'(led1), 32'h0);
        press(3'b010);
        chk("cnt_wrap_down", 32'(led1), 32'hF);

        // Simultaneous up/down, then clear
        press(3'b100);
        repeat (5) press(3'b001);
        chk("cnt_five", 32'(led1), 32'h5);
        press(3'b011);
        chk("cnt_simultaneous", 32'(led1), 32'h5);
        press(3'b100);
        chk("cnt_clear_again", 32'(led1), 32'h0);

        // Button 1 latency while button 0 chatters
        buttons[1] = 1'b1;
        n = 99;
        for (int k = 1; k <= 20; k++) begin
            buttons[0] = 1'($urandom);
            tick();
            if (pressed0[1] === 1'b1 && n == 99) n = k;
        end
        chk("indep_latency", n, 6);
        buttons = '0;
        repeat (10) tick();

        // Random hold lengths around the debounce threshold, with one reset inside
        for (int r = 0; r < 400; r++) begin
            buttons = NB'($urandom);
            if (r == 200) do_reset();
            repeat ($urandom_range(1, 7)) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
